// File: rtl/sm_dsp_pkg.sv
// Shared types and sign-magnitude <-> two's complement helpers for the basis expander.
// The helpers work on a 64-bit carrier; only the low w bits of the input are used.
package sm_dsp_pkg;

  localparam int SM_MAX_W = 64;
  typedef logic [SM_MAX_W-1:0] sm_word_t;

  typedef enum logic [1:0] {
    COEF_ZERO = 2'b00,
    COEF_POS  = 2'b01,
    COEF_RSVD = 2'b10,
    COEF_NEG  = 2'b11
  } coef_t;

  typedef enum logic {
    MODE_EXPAND = 1'b0,
    MODE_ACCUM  = 1'b1
  } mode_t;

  // -0 maps to 0 because the magnitude alone decides the result.
  function automatic sm_word_t sm_to_tc(input sm_word_t sm, input int w);
    sm_word_t mask;
    sm_word_t mag;
    mask = (sm_word_t'(1) << (w - 1)) - sm_word_t'(1);
    mag  = sm & mask;
    return sm[w-1] ? (~mag + sm_word_t'(1)) : mag;
  endfunction

  function automatic sm_word_t tc_to_sm(input sm_word_t tc, input int w);
    sm_word_t mask;
    sm_word_t mag;
    logic     sgn;
    mask = (sm_word_t'(1) << (w - 1)) - sm_word_t'(1);
    sgn  = tc[w-1];
    mag  = (sgn ? (~tc + sm_word_t'(1)) : tc) & mask;
    if (mag == '0) return '0;
    return mag | (sm_word_t'(sgn) << (w - 1));
  endfunction

endpackage

// File: rtl/sm_lane_mac.sv
// One output lane: applies a {0,+1,-1} coefficient to a two's complement sample and
// either loads or accumulates the contribution.
module sm_lane_mac
  import sm_dsp_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_first,
  input  coef_t                i_coef,
  input  logic signed [AW-1:0] i_smp,
  output logic signed [AW-1:0] o_acc
);

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_contrib;

  always_comb begin
    w_contrib = '0;
    case (i_coef)
      COEF_POS: w_contrib = i_smp;
      COEF_NEG: w_contrib = -i_smp;
      default:  w_contrib = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_first ? w_contrib : (r_acc + w_contrib);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/sm_basis_expander.sv
// Sign-magnitude basis expander: N lanes of {0,+1,-1} x sample, EXPAND or ACCUM per frame.
// Define SM_EXPAND_SAT_EN for W-bit saturating output lanes with a SAT_FLAG port.
module sm_basis_expander
  import sm_dsp_pkg::*;
#(
  parameter int W  = 12,
  parameter int N  = 8,
  parameter int AW = W + $clog2(N)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MODE,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [W-1:0]          IN_DATA,
  input  logic [$clog2(N)-1:0]  IN_IDX,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
`ifdef SM_EXPAND_SAT_EN
  output logic [N*W-1:0]        OUT_DATA,
  output logic [N-1:0]          SAT_FLAG,
`else
  output logic [N*AW-1:0]       OUT_DATA,
`endif
  input  logic                  CFG_WE,
  input  logic [$clog2(N)-1:0]  CFG_ROW,
  input  logic [$clog2(N)-1:0]  CFG_LANE,
  input  logic [1:0]            CFG_COEF
);

  localparam int IW = $clog2(N);
`ifdef SM_EXPAND_SAT_EN
  localparam int LW = W;
`else
  localparam int LW = AW;
`endif

  logic [2*N-1:0]       r_coef [N];
  logic [IW-1:0]        r_cnt;
  mode_t                r_mode;
  logic                 r_vld_p0;
  logic                 r_first_p0;
  logic                 r_last_p0;
  logic signed [AW-1:0] r_smp_p0;
  logic [2*N-1:0]       r_coef_p0;
  logic                 r_vld_p1;
  logic                 r_last_p1;
  logic                 r_out_vld;
  logic [N*LW-1:0]      r_out_data;

  logic                 w_stall;
  logic                 w_accept;
  logic                 w_cnt_zero;
  logic                 w_cnt_last;
  mode_t                w_mode;
  logic [IW-1:0]        w_row_sel;
  logic [IW-1:0]        w_cnt_nxt;
  logic [2*N-1:0]       w_row_coef;
  logic                 w_lane_en;
  logic signed [AW-1:0] w_acc [N];
  logic [N*LW-1:0]      w_out_nxt;

`ifdef SM_EXPAND_SAT_EN
  logic [N-1:0]         r_sat;
  logic [N-1:0]         w_sat_nxt;

  // Returns {flag, sign, magnitude}; magnitude clamps to the largest W-bit value.
  function automatic logic [W:0] sat_lane(input logic signed [AW-1:0] acc);
    logic [AW-1:0] sm;
    logic [AW-2:0] mag;
    logic          sgn;
    sm  = AW'(tc_to_sm(sm_word_t'(acc), AW));
    sgn = sm[AW-1];
    mag = sm[AW-2:0];
    if (mag > {{(AW-W){1'b0}}, {(W-1){1'b1}}}) return {1'b1, sgn, {(W-1){1'b1}}};
    return {1'b0, sgn, mag[W-2:0]};
  endfunction

  assign SAT_FLAG = r_sat;
`endif

  assign w_stall    = r_out_vld && !OUT_READY;
  assign IN_READY   = !w_stall;
  assign w_accept   = IN_VALID && !w_stall;
  assign OUT_VALID  = r_out_vld;
  assign OUT_DATA   = r_out_data;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_last = (r_cnt == IW'(N - 1));
  // Mode is latched only at a frame boundary; mid-frame MODE changes are ignored.
  assign w_mode     = w_cnt_zero ? mode_t'(MODE) : r_mode;
  assign w_row_sel  = (w_mode == MODE_ACCUM) ? r_cnt : IN_IDX;
  assign w_cnt_nxt  = (w_mode == MODE_ACCUM && !w_cnt_last) ? (r_cnt + IW'(1)) : '0;
  assign w_lane_en  = r_vld_p0 && !w_stall;

  always_comb begin
    w_row_coef = '0;
    for (int r = 0; r < N; r++) begin
      if (IW'(r) == w_row_sel) w_row_coef = r_coef[r];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int r = 0; r < N; r++) r_coef[r] <= '0;
    end else if (CFG_WE) begin
      for (int r = 0; r < N; r++) begin
        for (int l = 0; l < N; l++) begin
          if (IW'(r) == CFG_ROW && IW'(l) == CFG_LANE) r_coef[r][2*l +: 2] <= CFG_COEF;
        end
      end
    end
  end

  // Stage p0: capture sample, coefficient row and frame position
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_cnt      <= '0;
      r_mode     <= MODE_EXPAND;
      r_vld_p0   <= 1'b0;
      r_first_p0 <= 1'b0;
      r_last_p0  <= 1'b0;
    end else if (!w_stall) begin
      r_vld_p0 <= IN_VALID;
      if (IN_VALID) begin
        r_cnt      <= w_cnt_nxt;
        r_mode     <= w_mode;
        r_first_p0 <= w_cnt_zero;
        r_last_p0  <= (w_mode == MODE_EXPAND) || w_cnt_last;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_smp_p0  <= AW'(sm_to_tc(sm_word_t'(IN_DATA), W));
      r_coef_p0 <= w_row_coef;
    end
  end

  // Stage p1: per-lane coefficient apply and accumulate
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else if (!w_stall) begin
      r_vld_p1  <= r_vld_p0;
      r_last_p1 <= r_last_p0;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    sm_lane_mac #(.AW(AW)) u_mac (
      .i_clk   (CLK),
      .i_rst_n (RESET),
      .i_en    (w_lane_en),
      .i_first (r_first_p0),
      .i_coef  (coef_t'(r_coef_p0[2*k +: 2])),
      .i_smp   (r_smp_p0),
      .o_acc   (w_acc[k])
    );
  end

  always_comb begin
    w_out_nxt = '0;
`ifdef SM_EXPAND_SAT_EN
    w_sat_nxt = '0;
    for (int k = 0; k < N; k++) {w_sat_nxt[k], w_out_nxt[k*LW +: LW]} = sat_lane(w_acc[k]);
`else
    for (int k = 0; k < N; k++) w_out_nxt[k*LW +: LW] = LW'(tc_to_sm(sm_word_t'(w_acc[k]), AW));
`endif
  end

  // Output stage: sign-magnitude vector register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
`ifdef SM_EXPAND_SAT_EN
      r_sat      <= '0;
`endif
    end else if (!w_stall) begin
      r_out_vld <= r_vld_p1 && r_last_p1;
      if (r_vld_p1 && r_last_p1) begin
        r_out_data <= w_out_nxt;
`ifdef SM_EXPAND_SAT_EN
        r_sat      <= w_sat_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sm_basis_expander.sv
// Directed self-checking bench for sm_basis_expander (default or SM_EXPAND_SAT_EN build).
module tb_sm_basis_expander;

  localparam int W  = 12;
  localparam int N  = 8;
  localparam int IW = $clog2(N);
  localparam int AW = W + $clog2(N);
`ifdef SM_EXPAND_SAT_EN
  localparam int LW = W;
`else
  localparam int LW = AW;
`endif
  localparam int OW = N * LW;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          MODE = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [W-1:0]  IN_DATA = '0;
  logic [IW-1:0] IN_IDX = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;
  logic [OW-1:0] OUT_DATA;
`ifdef SM_EXPAND_SAT_EN
  logic [N-1:0]  SAT_FLAG;
`endif
  logic          CFG_WE = 1'b0;
  logic [IW-1:0] CFG_ROW = '0;
  logic [IW-1:0] CFG_LANE = '0;
  logic [1:0]    CFG_COEF = '0;

  int n_tests = 0;
  int n_fail  = 0;

  sm_basis_expander #(.W(W), .N(N)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MODE      (MODE),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_IDX    (IN_IDX),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
`ifdef SM_EXPAND_SAT_EN
    .SAT_FLAG  (SAT_FLAG),
`endif
    .CFG_WE    (CFG_WE),
    .CFG_ROW   (CFG_ROW),
    .CFG_LANE  (CFG_LANE),
    .CFG_COEF  (CFG_COEF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input int row, input int lane, input logic [1:0] c);
    CFG_WE = 1'b1; CFG_ROW = IW'(row); CFG_LANE = IW'(lane); CFG_COEF = c;
    tick();
    CFG_WE = 1'b0;
  endtask

  task automatic cfg_all(input logic [1:0] c);
    for (int r = 0; r < N; r++)
      for (int l = 0; l < N; l++) cfg(r, l, c);
  endtask

  function automatic logic [OW-1:0] vec(input int v[N]);
    logic [OW-1:0] res;
    logic [LW-1:0] e;
    res = '0;
    for (int k = 0; k < N; k++) begin
      if (v[k] < 0) e = LW'(-v[k]) | (LW'(1) << (LW - 1));
      else          e = LW'(v[k]);
      res[k*LW +: LW] = e;
    end
    return res;
  endfunction

  function automatic logic [OW-1:0] splat(input int v);
    int a[N];
    for (int k = 0; k < N; k++) a[k] = v;
    return vec(a);
  endfunction

  task automatic expand_chk(input string tag, input logic [W-1:0] d, input int idx,
                            input logic [OW-1:0] exp);
    MODE = 1'b0; IN_DATA = d; IN_IDX = IW'(idx); IN_VALID = 1'b1;
    chk({tag, "_in_ready"}, IN_READY, 1);
    tick();
    IN_VALID = 1'b0;
    chk({tag, "_vld_lat0"}, OUT_VALID, 0);
    tick();
    chk({tag, "_vld_lat1"}, OUT_VALID, 0);
    tick();
    chk({tag, "_vld_lat2"}, OUT_VALID, 1);
    chk({tag, "_data"}, OUT_DATA, exp);
    tick();
    chk({tag, "_vld_once"}, OUT_VALID, 0);
  endtask

  task automatic accum_frame(input string tag, input logic [W-1:0] d, input logic [OW-1:0] exp);
    int nv;
    nv = 0;
    for (int t = 0; t < 12; t++) begin
      MODE = 1'b1; IN_DATA = d; IN_VALID = (t < N);
      tick();
      nv += int'(OUT_VALID);
      if (t == N + 1) begin
        chk({tag, "_vld"}, OUT_VALID, 1);
        chk({tag, "_data"}, OUT_DATA, exp);
      end
    end
    IN_VALID = 1'b0;
    chk({tag, "_nvalid"}, nv, 1);
  endtask

  // Stream monitor: collects handshaken lane-0 values and checks stall behaviour
  bit            mon_en = 0;
  bit            was_stall = 0;
  logic [OW-1:0] held;
  logic [LW-1:0] rx[$];

  always @(negedge CLK) begin
    if (mon_en) begin
      if (OUT_VALID && OUT_READY) rx.push_back(OUT_DATA[LW-1:0]);
      if (OUT_VALID && !OUT_READY) begin
        chk("stall_in_ready", IN_READY, 0);
        if (was_stall) chk("stall_hold", OUT_DATA, held);
        held = OUT_DATA;
        was_stall = 1;
      end else begin
        was_stall = 0;
      end
    end
  end

  initial begin
    logic [1:0] row6 [N];
    logic [W-1:0] f2 [N];
    int a[N];
    int nv, sent, cyc;
    bit acc;
    logic [OW-1:0] exp_f1;

    row6 = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01};
    f2   = '{12'h001, 12'h802, 12'h003, 12'h804, 12'h005, 12'h806, 12'h007, 12'h808};

    repeat (3) tick();
    RESET = 1'b1;
    tick();
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_in_ready", IN_READY, 1);
`ifdef SM_EXPAND_SAT_EN
    chk("rst_sat_flag", SAT_FLAG, 0);
`endif

    for (int l = 0; l < N; l++) cfg(6, l, row6[l]);
    cfg(5, 0, 2'b10);
    cfg(5, 1, 2'b01);
    expand_chk("exp_row6", 12'h005, 6, vec('{0, 5, 0, -5, 0, -5, 0, 5}));
    expand_chk("exp_negzero", 12'h800, 6, splat(0));
    expand_chk("exp_rsvd", 12'h803, 5, vec('{0, -3, 0, 0, 0, 0, 0, 0}));

    // Two back-to-back ACCUM frames; MODE drop mid-frame 2 must be ignored
    cfg_all(2'b01);
`ifdef SM_EXPAND_SAT_EN
    exp_f1 = splat(2047);
`else
    exp_f1 = splat(16376);
`endif
    nv = 0;
    for (int t = 0; t < 20; t++) begin
      IN_VALID = (t < 2 * N);
      IN_DATA  = (t < N) ? 12'h7FF : ((t < 2 * N) ? f2[t - N] : 12'h000);
      MODE     = (t < N + 2);
      tick();
      nv += int'(OUT_VALID);
      if (t == N + 1) begin
        chk("acc_f1_vld", OUT_VALID, 1);
        chk("acc_f1_data", OUT_DATA, exp_f1);
`ifdef SM_EXPAND_SAT_EN
        chk("acc_f1_sat", SAT_FLAG, 8'hFF);
`endif
      end
      if (t == 2 * N + 1) begin
        chk("acc_f2_vld", OUT_VALID, 1);
        chk("acc_f2_data", OUT_DATA, splat(-4));
`ifdef SM_EXPAND_SAT_EN
        chk("acc_f2_sat", SAT_FLAG, 8'h00);
`endif
      end
    end
    chk("acc_nvalid", nv, 2);

    // EXPAND stream with a 5-cycle downstream stall
    MODE = 1'b0; IN_IDX = '0; sent = 0; cyc = 0; mon_en = 1;
    while (sent < 10 && cyc < 60) begin
      IN_VALID  = 1'b1;
      IN_DATA   = W'(sent + 1);
      OUT_READY = !(cyc >= 4 && cyc < 9);
      @(negedge CLK);
      acc = IN_READY;
      tick();
      if (acc) sent++;
      cyc++;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (5) tick();
    mon_en = 0;
    chk("stream_sent", sent, 10);
    chk("stream_cnt", rx.size(), 10);
    for (int i = 0; i < rx.size() && i < 10; i++) chk("stream_val", rx[i], i + 1);

    // Reset after 3 ACCUM samples: partial frame and coefficient table are discarded
    for (int t = 0; t < 3; t++) begin
      MODE = 1'b1; IN_DATA = 12'd100; IN_VALID = 1'b1;
      tick();
    end
    IN_VALID = 1'b0; RESET = 1'b0;
    tick();
    RESET = 1'b1;
    chk("midrst_out_valid", OUT_VALID, 0);
    chk("midrst_out_data", OUT_DATA, 0);
    accum_frame("midrst_zero_tbl", 12'h001, splat(0));
    cfg_all(2'b01);
    accum_frame("midrst_frame", 12'h001, splat(8));

    // Coefficient write in the same cycle as an acceptance applies only to later samples
    MODE = 1'b0; IN_IDX = '0; IN_DATA = 12'h007; IN_VALID = 1'b1;
    CFG_WE = 1'b1; CFG_ROW = '0; CFG_LANE = '0; CFG_COEF = 2'b11;
    tick();
    CFG_WE = 1'b0;
    tick();
    IN_VALID = 1'b0;
    tick();
    chk("cfg_old_vld", OUT_VALID, 1);
    chk("cfg_old_data", OUT_DATA, splat(7));
    tick();
    for (int k = 0; k < N; k++) a[k] = 7;
    a[0] = -7;
    chk("cfg_new_vld", OUT_VALID, 1);
    chk("cfg_new_data", OUT_DATA, vec(a));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
